// File: rtl/uart_word_sender_if.sv
`default_nettype none
// ============================================================================
// Module      : uart_word_sender_if
// Description : Request / byte-stream bundle between monitor logic, the word
//               formatter and the UART transmitter byte port.
// Revision    : 1.0 - initial release
// ============================================================================
interface uart_word_sender_if;
  logic        rdata_snd_start;
  logic [31:0] rdata_snd;
  logic        dump_running;
  logic        tx_ready;
  logic        tx_valid;
  logic [7:0]  tx_data;
  logic        flushing_wq;
  logic        sender_busy;

  modport master (
    input  rdata_snd_start, rdata_snd, dump_running, tx_ready,
    output tx_valid, tx_data, flushing_wq, sender_busy
  );

  modport slave (
    output rdata_snd_start, rdata_snd, dump_running, tx_ready,
    input  tx_valid, tx_data, flushing_wq, sender_busy
  );
endinterface
`default_nettype wire

// File: rtl/uart_word_sender.sv
`default_nettype none
// ============================================================================
// Module      : uart_word_sender
// Description : Formats a 32-bit word as 8 lowercase hex ASCII characters plus
//               a space or CR/LF separator onto a UART byte handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_word_sender #(
  parameter int WORDS_PER_LINE = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  uart_word_sender_if.master    bus
);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_HEX  = 3'd1,
    ST_SEP  = 3'd2,
    ST_LF   = 3'd3,
    ST_DONE = 3'd4
  } state_t;

  localparam logic [7:0] LAST_COL = 8'(WORDS_PER_LINE - 1);

  state_t      state, state_nxt;
  logic [31:0] shift, shift_nxt;
  logic [2:0]  char_cnt, char_cnt_nxt;
  logic [7:0]  wcnt, wcnt_nxt;
  logic        use_space, use_space_nxt;

  logic [3:0]  nib;
  logic [7:0]  hex_char;
  logic        out_valid;
  logic [7:0]  out_data;
  logic        out_flush;

  // 8'h57 = 8'h61 - 10, so nibbles 10..15 land on 'a'..'f'
  assign nib      = shift[31:28];
  assign hex_char = (nib < 4'd10) ? (8'h30 + {4'h0, nib}) : (8'h57 + {4'h0, nib});

  always_ff @(posedge clk) begin
    if (rst_n) begin
      state     <= ST_IDLE;
      shift     <= 32'h0;
      char_cnt  <= 3'd0;
      wcnt      <= 8'd0;
      use_space <= 1'b0;
    end else begin
      state     <= state_nxt;
      shift     <= shift_nxt;
      char_cnt  <= char_cnt_nxt;
      wcnt      <= wcnt_nxt;
      use_space <= use_space_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    shift_nxt     = shift;
    char_cnt_nxt  = char_cnt;
    wcnt_nxt      = wcnt;
    use_space_nxt = use_space;
    out_valid     = 1'b0;
    out_data      = 8'h00;
    out_flush     = 1'b0;

    case (state)
      ST_IDLE: begin
        if (!bus.dump_running) begin
          wcnt_nxt = 8'd0;
        end
        if (bus.rdata_snd_start) begin
          shift_nxt    = bus.rdata_snd;
          char_cnt_nxt = 3'd0;
          state_nxt    = ST_HEX;
        end
      end

      ST_HEX: begin
        out_valid = 1'b1;
        out_data  = hex_char;
        if (bus.tx_ready) begin
          shift_nxt    = {shift[27:0], 4'h0};
          char_cnt_nxt = char_cnt + 3'd1;
          if (char_cnt == 3'd7) begin
            state_nxt = ST_SEP;
            // Separator policy is frozen here; later dump_running changes
            // cannot alter a separator already being sent.
            if (bus.dump_running && (wcnt != LAST_COL)) begin
              use_space_nxt = 1'b1;
              wcnt_nxt      = wcnt + 8'd1;
            end else begin
              use_space_nxt = 1'b0;
              wcnt_nxt      = 8'd0;
            end
          end
        end
      end

      ST_SEP: begin
        out_valid = 1'b1;
        out_data  = use_space ? 8'h20 : 8'h0D;
        if (bus.tx_ready) begin
          state_nxt = use_space ? ST_DONE : ST_LF;
        end
      end

      ST_LF: begin
        out_valid = 1'b1;
        out_data  = 8'h0A;
        if (bus.tx_ready) begin
          state_nxt = ST_DONE;
        end
      end

      ST_DONE: begin
        out_flush = 1'b1;
        state_nxt = ST_IDLE;
      end

      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  assign bus.tx_valid    = out_valid;
  assign bus.tx_data     = out_data;
  assign bus.flushing_wq = out_flush;
  assign bus.sender_busy = (state != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_uart_word_sender.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_word_sender
// Description : Directed self-checking bench for uart_word_sender.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_word_sender;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;
  int   cyc;
  int   flush_cnt;
  int   flush_cyc;
  int   start_cyc;
  logic [7:0] q[$];
  logic       stall_prev;
  logic [7:0] stall_data;
  logic [3:0] bp_pat;

  uart_word_sender_if bus();

  uart_word_sender #(.WORDS_PER_LINE(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Byte capture, flush counting and stall-stability checking at mid-cycle
  always @(negedge clk) begin
    if (bus.tx_valid && bus.tx_ready) q.push_back(bus.tx_data);
    if (bus.flushing_wq) begin
      flush_cnt = flush_cnt + 1;
      flush_cyc = cyc;
    end
    if (stall_prev && bus.tx_valid) begin
      checks = checks + 1;
      assert (bus.tx_data === stall_data) else begin
        errors = errors + 1;
        $error("FAIL stall_stable: observed %0h expected %0h", bus.tx_data, stall_data);
      end
    end
    stall_prev = bus.tx_valid && !bus.tx_ready;
    stall_data = bus.tx_data;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks = checks + 1;
    assert (obs === exp) else begin
      errors = errors + 1;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_bytes(input string tag, input logic [79:0] exp, input int n);
    chk({tag, "_len"}, q.size(), n);
    for (int i = 0; i < n && i < q.size(); i++)
      chk($sformatf("%s[%0d]", tag, i), {24'h0, q[i]}, {24'h0, exp[(n-1-i)*8 +: 8]});
  endtask

  task automatic send_word(input logic [31:0] w, input bit bp, input int inj);
    q.delete();
    flush_cnt = 0;
    bus.rdata_snd_start = 1'b1;
    bus.rdata_snd       = w;
    start_cyc           = cyc;
    @(posedge clk); #1;
    bus.rdata_snd_start = 1'b0;
    bus.rdata_snd       = 32'h0;
    for (int i = 0; i < 400 && flush_cnt == 0; i++) begin
      bus.tx_ready        = bp ? bp_pat[i % 4] : 1'b1;
      bus.rdata_snd_start = (i == inj);
      bus.rdata_snd       = (i == inj) ? 32'hFFFF_FFFF : 32'h0;
      @(posedge clk); #1;
    end
    bus.rdata_snd_start = 1'b0;
    bus.tx_ready        = 1'b1;
    repeat (3) @(posedge clk);
    #1;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    checks = 0; errors = 0; cyc = 0; flush_cnt = 0; flush_cyc = 0; start_cyc = 0;
    stall_prev = 1'b0; stall_data = 8'h00;
    bp_pat = 4'b1001;
    rst_n = 1'b1;
    bus.rdata_snd_start = 1'b0;
    bus.rdata_snd       = 32'h0;
    bus.dump_running    = 1'b0;
    bus.tx_ready        = 1'b1;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_tx_valid", bus.tx_valid, 0);
    chk("rst_tx_data", bus.tx_data, 8'h00);
    chk("rst_flush", bus.flushing_wq, 0);
    chk("rst_busy", bus.sender_busy, 0);
    rst_n = 1'b0;
    @(posedge clk); #1;

    // Single word, no dump
    send_word(32'hDEAD_BEEF, 1'b0, -1);
    check_bytes("deadbeef", 80'h6465_6164_6265_6566_0D0A, 10);
    chk("deadbeef_flushes", flush_cnt, 1);
    chk("deadbeef_latency", flush_cyc - start_cyc, 11);

    // Back-pressure
    send_word(32'h0123_ABCD, 1'b1, -1);
    check_bytes("bp", 80'h3031_3233_6162_6364_0D0A, 10);
    chk("bp_flushes", flush_cnt, 1);

    // Dump line wrap
    bus.dump_running = 1'b1;
    send_word(32'h0, 1'b0, -1);
    check_bytes("dump_w0", 80'h30_3030_3030_3030_3020, 9);
    chk("dump_w0_latency", flush_cyc - start_cyc, 10);
    send_word(32'h1, 1'b0, -1);
    check_bytes("dump_w1", 80'h30_3030_3030_3030_3120, 9);
    send_word(32'h2, 1'b0, -1);
    check_bytes("dump_w2", 80'h30_3030_3030_3030_3220, 9);
    send_word(32'h3, 1'b0, -1);
    check_bytes("dump_w3", 80'h3030_3030_3030_3033_0D0A, 10);
    chk("dump_w3_latency", flush_cyc - start_cyc, 11);
    send_word(32'h4, 1'b0, -1);
    check_bytes("dump_w4", 80'h30_3030_3030_3030_3420, 9);
    bus.dump_running = 1'b0;
    send_word(32'h5, 1'b0, -1);
    check_bytes("dump_w5", 80'h3030_3030_3030_3035_0D0A, 10);

    // Column restarts at 0 after the wrap, and again after an idle gap
    bus.dump_running = 1'b1;
    send_word(32'h7, 1'b0, -1);
    check_bytes("col_w7", 80'h30_3030_3030_3030_3720, 9);
    send_word(32'h8, 1'b0, -1);
    check_bytes("col_w8", 80'h30_3030_3030_3030_3820, 9);
    bus.dump_running = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    bus.dump_running = 1'b1;
    send_word(32'h9, 1'b0, -1);
    check_bytes("col_w9", 80'h30_3030_3030_3030_3920, 9);
    send_word(32'hA, 1'b0, -1);
    check_bytes("col_w10", 80'h30_3030_3030_3030_6120, 9);
    bus.dump_running = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Start while busy is ignored
    send_word(32'h1111_1111, 1'b0, 2);
    check_bytes("busy_req", 80'h3131_3131_3131_3131_0D0A, 10);
    chk("busy_flushes", flush_cnt, 1);
    chk("busy_idle_after", bus.sender_busy, 0);

    // Reset mid-word
    q.delete();
    flush_cnt = 0;
    bus.rdata_snd_start = 1'b1;
    bus.rdata_snd       = 32'h1234_5678;
    @(posedge clk); #1;
    bus.rdata_snd_start = 1'b0;
    bus.tx_ready        = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    rst_n        = 1'b1;
    bus.tx_ready = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    chk("midrst_tx_valid", bus.tx_valid, 0);
    chk("midrst_busy", bus.sender_busy, 0);
    chk("midrst_tx_data", bus.tx_data, 8'h00);
    bus.tx_ready = 1'b1;
    repeat (12) @(posedge clk);
    #1;
    chk("midrst_no_flush", flush_cnt, 0);
    check_bytes("midrst_partial", 80'h3132_3334, 4);
    send_word(32'hA5A5_A5A5, 1'b0, -1);
    check_bytes("after_rst", 80'h6135_6135_6135_6135_0D0A, 10);
    chk("after_rst_latency", flush_cyc - start_cyc, 11);

    // Request coincident with DONE ignored, next cycle accepted
    q.delete();
    flush_cnt = 0;
    bus.rdata_snd_start = 1'b1;
    bus.rdata_snd       = 32'h2222_2222;
    @(posedge clk); #1;
    bus.rdata_snd_start = 1'b0;
    for (int i = 0; i < 40 && !bus.flushing_wq; i++) begin
      @(posedge clk); #1;
    end
    chk("done_seen", bus.flushing_wq, 1);
    bus.rdata_snd_start = 1'b1;
    bus.rdata_snd       = 32'hCAFE_F00D;
    @(posedge clk); #1;
    chk("done_req_ignored", bus.sender_busy, 0);
    q.delete();
    flush_cnt = 0;
    bus.rdata_snd = 32'h9ABC_DEF0;
    @(posedge clk); #1;
    bus.rdata_snd_start = 1'b0;
    bus.rdata_snd       = 32'h0;
    chk("next_req_valid", bus.tx_valid, 1);
    chk("next_req_first", bus.tx_data, 8'h39);
    for (int i = 0; i < 40 && flush_cnt == 0; i++) begin
      @(posedge clk); #1;
    end
    check_bytes("next_req", 80'h3961_6263_6465_6630_0D0A, 10);
    chk("next_req_flushes", flush_cnt, 1);

    repeat (2) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/uart_word_sender.md
# uart_word_sender

Transmit-side formatter of the UART monitor. It takes a 32-bit word, typically a memory, register or PC readout, together with a one-cycle send strobe from the monitor logic. It emits the word as eight lowercase hex ASCII characters plus a separator into the UART transmitter byte interface. When the last character has been accepted it pulses `flushing_wq`, which advances the monitor's dump state machine to the next word.

## Interface
- `WORDS_PER_LINE`, default 4: number of words per line during a dump (2–255).
- Reset is synchronous, active-high. There is one clock; reset uses the codebase's port name `rst_n`, and asserted = 1.
- `clk` input, 1 bit: system clock. All logic is on the rising edge.
- `rst_n` input, 1 bit: synchronous reset, active-high.
- `rdata_snd_start` input, 1 bit: one-cycle request to send `rdata_snd`.
- `rdata_snd` input, 32 bits: word to send. Sampled only in the cycle a request is accepted.
- `dump_running` input, 1 bit: a multi-word dump is in progress. Selects the separator policy.
- `tx_ready` input, 1 bit: the UART transmitter can accept a byte this cycle.
- `tx_valid` output, 1 bit: `tx_data` is valid.
- `tx_data` output, 8 bits: ASCII byte to transmit.
- `flushing_wq` output, 1 bit: one-cycle pulse when the word and its separator have been fully handed off.
- `sender_busy` output, 1 bit: high whenever the state is not IDLE.

## Operation
- Reset values: state IDLE, `tx_valid`=0, `tx_data`=8'h00, `flushing_wq`=0, `sender_busy`=0, shift register 0, char counter 0, word-in-line counter 0.
- FSM states:
  - IDLE: waits for a request.
  - HEX: sends 8 characters.
  - SEP: sends a space or CR.
  - LF: sends LF.
  - DONE: one cycle, drives `flushing_wq`.
- IDLE with `rdata_snd_start`=1:
  - Latch `rdata_snd` into the shift register.
  - Clear the char counter.
  - Go to HEX.
- `rdata_snd_start` outside IDLE is ignored. No latch occurs and no state change occurs.
- HEX:
  - `tx_data` = ASCII of shift[31:28].
  - Nibble 0–9 maps to 8'h30+n. Nibble 10–15 maps to 8'h61+(n−10).
  - On a handshake (`tx_valid & tx_ready`): shift left by 4 and increment the char counter (3 bits).
  - After the 8th handshake (counter wraps 7→0), go to SEP.
- Separator decision, made on entering SEP using the word-in-line counter `wcnt`:
  - If `dump_running`=1 and `wcnt` ≠ `WORDS_PER_LINE`−1: SEP sends 8'h20 (space), then goes to DONE, and `wcnt` increments.
  - Otherwise: SEP sends 8'h0D (CR), then LF sends 8'h0A, then DONE, and `wcnt` clears to 0.
- `wcnt` is also cleared in any cycle where the state is IDLE and `dump_running`=0. A new dump therefore always starts at column 0.
- DONE: `flushing_wq`=1 for exactly one cycle, then IDLE. `tx_valid`=0 in DONE and in IDLE.
- `tx_valid` is high in HEX, SEP and LF.
- `tx_data` is stable while `tx_valid`=1 and `tx_ready`=0. It changes only after a handshake.
- `tx_ready` is ignored when `tx_valid`=0.

## Timing
- A request accepted at edge T gives `tx_valid`=1 with the first character from cycle T+1.
- Each character takes at least 1 cycle and is held indefinitely under back-pressure.
- With `tx_ready` held at 1:
  - Space case: `flushing_wq` high 10 cycles after the accepting edge (8 hex + 1 SEP + DONE).
  - CR/LF case: `flushing_wq` high 11 cycles after the accepting edge.
- The earliest next request is accepted in the cycle after DONE, i.e. the first IDLE cycle. A request presented in the same cycle as DONE is ignored.
- Reset mid-operation:
  - At the next edge, all state returns to the reset values and `tx_valid` drops.
  - A partially sent word is abandoned and no `flushing_wq` is issued.
- Reset has priority over every other input in the same cycle.
- `dump_running` changing during a word affects only the separator decision taken on the HEX→SEP transition.

## Test plan
- Single word, no dump: `rdata_snd`=32'hDEADBEEF, `dump_running`=0, `tx_ready`=1.
  - Bytes 64 65 61 64 62 65 65 66 0D 0A ("deadbeef\r\n").
  - `flushing_wq` pulses once, 11 cycles after the start edge.
- Back-pressure: word 32'h0123ABCD, `tx_ready` toggling 1,0,0,1,…
  - Bytes 30 31 32 33 61 62 63 64 0D 0A.
  - `tx_data` is stable during every stall.
  - Each byte is counted exactly once.
- Dump line wrap, `WORDS_PER_LINE`=4, `dump_running`=1: send 5 words 0,1,2,3,4.
  - Words 0–2 end in 20.
  - Word 3 ends in 0D 0A.
  - Word 4 ends in 20.
  - Drop `dump_running` and send a 6th word: it ends in 0D 0A with `wcnt`=0 afterwards.
- Start while busy: pulse `rdata_snd_start` with 32'hFFFFFFFF during the 3rd character of 32'h11111111.
  - Output is 31×8 + separator only.
  - There is exactly one `flushing_wq`.
- Reset mid-word: assert `rst_n`=1 after the 4th handshake.
  - Next cycle: `tx_valid`=0, `sender_busy`=0, and no `flushing_wq`.
  - A following request for 32'hA5A5A5A5 outputs 61 35 61 35 61 35 61 35 0D 0A.
- Request coincident with DONE is ignored. A request one cycle later is accepted and the first byte appears the following cycle.
